// File: rtl/regwrite_pkg.sv
// ============================================================================
//  Module      : regwrite_pkg
//  Description : Shared types and constants for the register-file write arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package regwrite_pkg;

    localparam int REGWRITE_DATA_W = 8;
    localparam int REGWRITE_ADDR_W = 2;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage : regwrite_pkg

`default_nettype wire

// File: rtl/regwrite_if.sv
// ============================================================================
//  Module      : regwrite_if
//  Description : Requester handshakes plus register-file write port bundle.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface regwrite_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              clear;
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_reg;
    logic [DATA_W-1:0] mem_data;
    logic              reg_write;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              grant;
    logic              busy;

    modport master (
        output clear, alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
        input  alu_ready, mem_ready, reg_write, write_reg, write_data, grant, busy
    );

    modport slave (
        input  clear, alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
        output alu_ready, mem_ready, reg_write, write_reg, write_data, grant, busy
    );
endinterface : regwrite_if

`default_nettype wire

// File: rtl/regwrite_slot.sv
// ============================================================================
//  Module      : regwrite_slot
//  Description : One-entry holding buffer (target, data, age stamp) per requester.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module regwrite_slot #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              load,
    input  wire logic              drain,
    input  wire logic              flush,
    input  wire logic [ADDR_W-1:0] load_reg,
    input  wire logic [DATA_W-1:0] load_data,
    input  wire logic              load_age,
    output logic                   full,
    output logic      [ADDR_W-1:0] slot_reg,
    output logic      [DATA_W-1:0] slot_data,
    output logic                   slot_age
);

    logic              r_full;
    logic [ADDR_W-1:0] r_reg;
    logic [DATA_W-1:0] r_data;
    logic              r_age;

    // A load in the same cycle as a drain refills the slot, so load wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 1'b0;
            r_reg  <= '0;
            r_data <= '0;
            r_age  <= 1'b0;
        end else if (flush) begin
            r_full <= 1'b0;
        end else if (load) begin
            r_full <= 1'b1;
            r_reg  <= load_reg;
            r_data <= load_data;
            r_age  <= load_age;
        end else if (drain) begin
            r_full <= 1'b0;
        end
    end

    assign full      = r_full;
    assign slot_reg  = r_reg;
    assign slot_data = r_data;
    assign slot_age  = r_age;

endmodule : regwrite_slot

`default_nettype wire

// File: rtl/regwrite_arbiter.sv
// ============================================================================
//  Module      : regwrite_arbiter
//  Description : Arbitrates ALU and load writes onto one register-file port and
//                sequences a full-file clear after reset or on request.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module regwrite_arbiter
    import regwrite_pkg::*;
#(
    parameter int DATA_W = REGWRITE_DATA_W,
    parameter int ADDR_W = REGWRITE_ADDR_W,
    parameter int NREG   = 1 << REGWRITE_ADDR_W
) (
    input wire logic clk,
    input wire logic rst,
    regwrite_if.slave bus
);

    localparam logic [ADDR_W-1:0] c_last_reg = ADDR_W'(NREG - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_age;
    logic              r_rr;
    logic              r_busy;
    logic              r_reg_write;
    logic [ADDR_W-1:0] r_write_reg;
    logic [DATA_W-1:0] r_write_data;
    logic              r_grant;

    logic              w_alu_full, w_mem_full;
    logic [ADDR_W-1:0] w_alu_reg,  w_mem_reg;
    logic [DATA_W-1:0] w_alu_data, w_mem_data;
    logic              w_alu_age,  w_mem_age;
    logic              w_accept_ok;
    logic              w_do_write;
    logic              w_sel;
    logic              w_rr_step;
    logic              w_alu_drain, w_mem_drain;
    logic              w_alu_ready, w_mem_ready;
    logic [ADDR_W-1:0] w_sel_reg;
    logic [DATA_W-1:0] w_sel_data;

    // Busy lags the state by one cycle so requesters stay held off until
    // the final clear write has left the output stage.
    assign w_accept_ok = (r_state == RUN) && !r_busy && !bus.clear;
    assign w_do_write  = (r_state == RUN) && !bus.clear && (w_alu_full || w_mem_full);

    always_comb begin
        w_sel     = SRC_ALU;
        w_rr_step = 1'b0;
        if (w_mem_full && !w_alu_full) begin
            w_sel = SRC_MEM;
        end else if (w_alu_full && w_mem_full) begin
            // Stamps differ by at most one tick; the older one matches the
            // current toggle value.
            if (w_alu_age != w_mem_age) begin
                w_sel = (w_alu_age == r_age) ? SRC_ALU : SRC_MEM;
            end else if (w_alu_reg != w_mem_reg) begin
                w_sel     = r_rr;
                w_rr_step = 1'b1;
            end
        end
    end

    assign w_alu_drain = w_do_write && (w_sel == SRC_ALU);
    assign w_mem_drain = w_do_write && (w_sel == SRC_MEM);
    assign w_alu_ready = w_accept_ok && (!w_alu_full || w_alu_drain);
    assign w_mem_ready = w_accept_ok && (!w_mem_full || w_mem_drain);
    assign w_sel_reg   = (w_sel == SRC_MEM) ? w_mem_reg  : w_alu_reg;
    assign w_sel_data  = (w_sel == SRC_MEM) ? w_mem_data : w_alu_data;

    regwrite_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_alu_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (bus.alu_valid && w_alu_ready),
        .drain     (w_alu_drain),
        .flush     (bus.clear),
        .load_reg  (bus.alu_reg),
        .load_data (bus.alu_data),
        .load_age  (r_age),
        .full      (w_alu_full),
        .slot_reg  (w_alu_reg),
        .slot_data (w_alu_data),
        .slot_age  (w_alu_age)
    );

    regwrite_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (bus.mem_valid && w_mem_ready),
        .drain     (w_mem_drain),
        .flush     (bus.clear),
        .load_reg  (bus.mem_reg),
        .load_data (bus.mem_data),
        .load_age  (r_age),
        .full      (w_mem_full),
        .slot_reg  (w_mem_reg),
        .slot_data (w_mem_data),
        .slot_age  (w_mem_age)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= CLEAR;
            r_cnt        <= '0;
            r_age        <= 1'b0;
            r_rr         <= SRC_ALU;
            r_busy       <= 1'b1;
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
            r_grant      <= SRC_ALU;
        end else begin
            r_age  <= ~r_age;
            r_busy <= (r_state == CLEAR) || bus.clear;
            if (bus.clear) begin
                r_state     <= CLEAR;
                r_cnt       <= '0;
                r_reg_write <= 1'b0;
            end else if (r_state == CLEAR) begin
                r_reg_write  <= 1'b1;
                r_write_reg  <= r_cnt;
                r_write_data <= '0;
                r_grant      <= SRC_ALU;
                r_cnt        <= r_cnt + 1'b1;
                if (r_cnt == c_last_reg) begin
                    r_state <= RUN;
                end
            end else if (w_do_write) begin
                r_reg_write  <= 1'b1;
                r_write_reg  <= w_sel_reg;
                r_write_data <= w_sel_data;
                r_grant      <= w_sel;
                if (w_rr_step) begin
                    r_rr <= ~r_rr;
                end
            end else begin
                r_reg_write <= 1'b0;
            end
        end
    end

    assign bus.alu_ready  = w_alu_ready;
    assign bus.mem_ready  = w_mem_ready;
    assign bus.reg_write  = r_reg_write;
    assign bus.write_reg  = r_write_reg;
    assign bus.write_data = r_write_data;
    assign bus.grant      = r_grant;
    assign bus.busy       = r_busy;

endmodule : regwrite_arbiter

`default_nettype wire

// File: tb/tb_regwrite_arbiter.sv
// ============================================================================
//  Module      : tb_regwrite_arbiter
//  Description : Self-checking bench for regwrite_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regwrite_arbiter;

    typedef struct {
        logic [1:0] r;
        logic [7:0] d;
        logic       g;
    } wr_t;

    typedef struct {
        logic       av;
        logic [1:0] ar;
        logic [7:0] ad;
        logic       mv;
        logic [1:0] mr;
        logic [7:0] md;
        logic       first;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    wr_t  exp_q[$];
    wr_t  mon_e;
    vec_t vec[8];

    regwrite_if #(.DATA_W(8), .ADDR_W(2)) bus ();

    regwrite_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] r, input logic [7:0] d, input logic g);
        wr_t e;
        e.r = r;
        e.d = d;
        e.g = g;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        bus.clear     = 1'b0;
        bus.alu_valid = 1'b0;
        bus.alu_reg   = '0;
        bus.alu_data  = '0;
        bus.mem_valid = 1'b0;
        bus.mem_reg   = '0;
        bus.mem_data  = '0;
    endtask

    // Scoreboard: every write the DUT presents must match the queue head.
    always @(negedge clk) begin
        if (!rst && bus.reg_write) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got reg %0d data %0h grant %0d, expected no write",
                         bus.write_reg, bus.write_data, bus.grant);
            end else begin
                mon_e = exp_q.pop_front();
                check("write{reg,data,grant}", {21'd0, bus.write_reg, bus.write_data, bus.grant},
                      {21'd0, mon_e.r, mon_e.d, mon_e.g});
            end
        end
    end

    task automatic clear_sequence_checks(input string tag);
        for (int c = 0; c < 4; c++) begin
            step();
            check({tag, "_clr_rw"}, 32'(bus.reg_write), 32'd1);
            check({tag, "_clr_reg"}, 32'(bus.write_reg), 32'(c));
            check({tag, "_clr_busy"}, 32'(bus.busy), 32'd1);
        end
        step();
        check({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
        check({tag, "_ready"}, {30'd0, bus.alu_ready, bus.mem_ready}, 32'd3);
        check({tag, "_rw_idle"}, 32'(bus.reg_write), 32'd0);
    endtask

    initial begin
        vec[0] = '{1'b1, 2'd2, 8'h11, 1'b0, 2'd0, 8'h00, 1'b0};
        vec[1] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 8'h5A, 1'b1};
        vec[2] = '{1'b1, 2'd3, 8'hAA, 1'b1, 2'd3, 8'h55, 1'b0};
        vec[3] = '{1'b1, 2'd1, 8'h10, 1'b1, 2'd2, 8'h20, 1'b0};
        vec[4] = '{1'b1, 2'd1, 8'h30, 1'b1, 2'd2, 8'h40, 1'b1};
        vec[5] = '{1'b1, 2'd0, 8'h50, 1'b1, 2'd3, 8'h60, 1'b0};
        vec[6] = '{1'b1, 2'd2, 8'h70, 1'b1, 2'd2, 8'h80, 1'b0};
        vec[7] = '{1'b1, 2'd1, 8'h90, 1'b1, 2'd0, 8'hA0, 1'b1};

        idle_inputs();
        rst = 1'b1;
        step();
        step();
        check("rst_outputs", {17'd0, bus.reg_write, bus.write_reg, bus.write_data, bus.grant, bus.busy},
              {17'd0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1});
        check("rst_ready", {30'd0, bus.alu_ready, bus.mem_ready}, 32'd0);

        // Initial clear sequence
        rst = 1'b0;
        for (int c = 0; c < 4; c++) push(2'(c), 8'h00, 1'b0);
        clear_sequence_checks("init");

        // ALU-only back-to-back stream
        bus.alu_valid = 1'b1;
        bus.alu_reg   = 2'd2;
        bus.alu_data  = 8'h11;
        push(2'd2, 8'h11, 1'b0);
        step();
        check("stream_ready0", 32'(bus.alu_ready), 32'd1);
        bus.alu_data = 8'h22;
        push(2'd2, 8'h22, 1'b0);
        step();
        check("stream_ready1", 32'(bus.alu_ready), 32'd1);
        check("stream_w0", {23'd0, bus.reg_write, bus.write_data}, {23'd0, 1'b1, 8'h11});
        bus.alu_data = 8'h33;
        push(2'd2, 8'h33, 1'b0);
        step();
        bus.alu_valid = 1'b0;
        check("stream_w1", {23'd0, bus.reg_write, bus.write_data}, {23'd0, 1'b1, 8'h22});
        step();
        check("stream_w2", {23'd0, bus.reg_write, bus.write_data}, {23'd0, 1'b1, 8'h33});
        step();
        check("stream_idle", 32'(bus.reg_write), 32'd0);

        // Table of single requests and same-cycle pairs
        for (int i = 0; i < 8; i++) begin
            bus.alu_valid = vec[i].av;
            bus.alu_reg   = vec[i].ar;
            bus.alu_data  = vec[i].ad;
            bus.mem_valid = vec[i].mv;
            bus.mem_reg   = vec[i].mr;
            bus.mem_data  = vec[i].md;
            if (vec[i].av && vec[i].mv) begin
                if (vec[i].first == 1'b0) begin
                    push(vec[i].ar, vec[i].ad, 1'b0);
                    push(vec[i].mr, vec[i].md, 1'b1);
                end else begin
                    push(vec[i].mr, vec[i].md, 1'b1);
                    push(vec[i].ar, vec[i].ad, 1'b0);
                end
            end else if (vec[i].av) begin
                push(vec[i].ar, vec[i].ad, 1'b0);
            end else begin
                push(vec[i].mr, vec[i].md, 1'b1);
            end
            step();
            idle_inputs();
            if (vec[i].av && vec[i].mv) begin
                check($sformatf("vec%0d_ready{alu,mem}", i), {30'd0, bus.alu_ready, bus.mem_ready},
                      vec[i].first ? 32'd1 : 32'd2);
            end
            step();
            check($sformatf("vec%0d_first{rw,grant}", i), {30'd0, bus.reg_write, bus.grant},
                  {30'd0, 1'b1, vec[i].first});
            if (vec[i].av && vec[i].mv) begin
                step();
                check($sformatf("vec%0d_second{rw,grant}", i), {30'd0, bus.reg_write, bus.grant},
                      {30'd0, 1'b1, ~vec[i].first});
            end
            step();
            check($sformatf("vec%0d_idle", i), 32'(bus.reg_write), 32'd0);
        end

        // MEM entry older than a fresh ALU entry goes first
        bus.alu_valid = 1'b1; bus.alu_reg = 2'd2; bus.alu_data = 8'hA1;
        bus.mem_valid = 1'b1; bus.mem_reg = 2'd2; bus.mem_data = 8'hB1;
        push(2'd2, 8'hA1, 1'b0);
        push(2'd2, 8'hB1, 1'b1);
        push(2'd1, 8'hC1, 1'b0);
        step();
        bus.mem_valid = 1'b0;
        bus.alu_reg   = 2'd1;
        bus.alu_data  = 8'hC1;
        step();
        bus.alu_valid = 1'b0;
        check("age_w0", {23'd0, bus.grant, bus.write_data}, {23'd0, 1'b0, 8'hA1});
        step();
        check("age_w1", {23'd0, bus.grant, bus.write_data}, {23'd0, 1'b1, 8'hB1});
        step();
        check("age_w2", {23'd0, bus.grant, bus.write_data}, {23'd0, 1'b0, 8'hC1});
        step();
        check("age_idle", 32'(bus.reg_write), 32'd0);

        // Clear with both slots pending, then reset during the clear
        bus.alu_valid = 1'b1; bus.alu_reg = 2'd1; bus.alu_data = 8'hEE;
        bus.mem_valid = 1'b1; bus.mem_reg = 2'd2; bus.mem_data = 8'hDD;
        step();
        idle_inputs();
        bus.clear = 1'b1;
        for (int c = 0; c < 4; c++) push(2'(c), 8'h00, 1'b0);
        #1;
        check("clear_ready", {30'd0, bus.alu_ready, bus.mem_ready}, 32'd0);
        step();
        bus.clear = 1'b0;
        check("clear_no_write", 32'(bus.reg_write), 32'd0);
        check("clear_busy", 32'(bus.busy), 32'd1);
        step();
        check("clear_w0", {29'd0, bus.reg_write, bus.write_reg}, {29'd0, 1'b1, 2'd0});
        step();
        check("clear_w1", {29'd0, bus.reg_write, bus.write_reg}, {29'd0, 1'b1, 2'd1});
        rst = 1'b1;
        #1;
        check("midrst_outputs", {20'd0, bus.reg_write, bus.write_reg, bus.busy, bus.write_data},
              {20'd0, 1'b0, 2'd0, 1'b1, 8'd0});
        exp_q.delete();
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) push(2'(c), 8'h00, 1'b0);
        clear_sequence_checks("rerst");

        step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_regwrite_arbiter

`default_nettype wire

// File: doc/regwrite_arbiter.md
# regwrite_arbiter

Shares the single register-file write port between the ALU writeback path and the memory-load path, and sequences a full-file clear after reset or on request. Each requester gets a one-entry holding slot with a valid/ready handshake. The block drives the register file's RegWrite/WriteReg/WriteData inputs from a registered output stage, so the file sees exactly one clean write per clock.

## Interface
- DATA_W, 8, register data width
- ADDR_W, 2, register index width
- NREG, 4, registers cleared by the clear sequence (2**ADDR_W)

- Clock  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-high
- Clear  in  1  request a full-file clear (level, sampled per cycle)
- AluValid  in  1  ALU write request
- AluReady  out  1  ALU slot can accept this cycle
- AluReg  in  ADDR_W  ALU target register
- AluData  in  DATA_W  ALU write value
- MemValid  in  1  load write request
- MemReady  out  1  load slot can accept this cycle
- MemReg  in  ADDR_W  load target register
- MemData  in  DATA_W  load write value
- RegWrite  out  1  write enable to register file
- WriteReg  out  ADDR_W  register-file write index
- WriteData  out  DATA_W  register-file write data
- Grant  out  1  source of current write: 0 = ALU/clear, 1 = MEM
- Busy  out  1  clear sequence in progress

## Operation
- States: CLEAR, RUN. Reset forces CLEAR with clear counter 0.
- CLEAR: each cycle, load the output stage with RegWrite=1, WriteReg=counter, WriteData=0, Grant=0, then increment the counter. The edge that loads counter NREG-1 moves the state to RUN. Both Ready outputs are 0. Valid inputs are ignored.
- RUN, Clear=1: both slots are discarded (not written), the counter is set to 0, and the next state is CLEAR. Clear=1 while in CLEAR restarts the counter at 0.
- Slot acceptance: transfer occurs when Valid and Ready are both high at a rising edge. The slot captures Reg/Data and an age stamp (a free-running 1-bit arrival toggle is sufficient; same-edge arrivals are "same age").
- Ready = RUN, and Clear=0, and (slot empty, or slot granted this cycle). This gives back-to-back throughput of one write per cycle per slot.
- Arbitration, evaluated each RUN cycle among full slots:
  - Only one slot full: grant that slot.
  - Both full, different age: grant the older slot.
  - Both full, same age, same target register: grant ALU first, so MEM is written last and wins.
  - Both full, same age, different target: grant by round-robin pointer. The pointer starts at ALU after reset and toggles after each such decision.
- The granted slot empties at the edge that loads the output stage. No slot full: RegWrite=0; WriteReg, WriteData and Grant hold their values.

## Timing
- Reset values: RegWrite=0, WriteReg=0, WriteData=0, Grant=0, Busy=1, AluReady=0, MemReady=0, both slots empty, round-robin pointer=ALU.
- After Reset deasserts:
  - Clear writes to registers 0..NREG-1 appear on RegWrite during cycles 1..NREG.
  - Busy falls in cycle NREG+1, and Ready rises in the same cycle.
- Latency: a request accepted at edge N with no contention loads the output stage at edge N+1. The register file commits it at edge N+2.
- With contention, the losing slot adds one cycle per write ahead of it (maximum one).
- Reset asserted mid-operation: all state clears immediately, including pending slots and any write in the output stage, and the clear sequence restarts.

## Structure
- Package regwrite_pkg holds:
  - the state enum {CLEAR, RUN}
  - the DATA_W/ADDR_W defaults
  - source encodings SRC_ALU=0, SRC_MEM=1
- Sub-module regwrite_slot: one-entry holding buffer with full flag, Reg, Data and age stamp; load/drain/flush inputs. It is instantiated twice.
- Arbiter, FSM, clear counter and output stage live in the top module.

## Test plan
- Reset pulse, then release → RegWrite=1 with WriteReg 0,1,2,3, WriteData=0 over four cycles. Busy=1 through cycle 4, Busy=0 and AluReady=MemReady=1 in cycle 5.
- ALU-only stream: AluValid with Reg=2, Data=0x11/0x22/0x33 on consecutive cycles → AluReady stays 1, and WriteReg=2 carries 0x11, 0x22, 0x33 on three consecutive cycles starting two cycles after the first accept.
- Same-cycle ALU Reg=3 Data=0xAA and MEM Reg=3 Data=0x55 → writes 0xAA (Grant=0), then 0x55 (Grant=1). MemReady=0 for one cycle.
- Same-cycle ALU Reg=1 and MEM Reg=2, repeated twice → first pair grants ALU first, second pair grants MEM first.
- MEM accepted one cycle before ALU, both pending → MEM written first.
- Pending ALU and MEM entries, then Clear=1 → neither entry is written, and four zero-writes follow. Reset asserted during the clear restarts it at register 0.
